// File: rtl/muxn_pkg.sv
// Shared constants and helpers for the muxn_pipe select stage.
package muxn_pkg;

    localparam int MUXN_MAX_N = 16;

    function automatic int muxn_clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A select port is always at least one bit wide, even for N=1 corner cases.
    function automatic int muxn_sel_w(input int n);
        return (muxn_clog2(n) < 1) ? 1 : muxn_clog2(n);
    endfunction

    function automatic bit muxn_n_ok(input int n);
        return (n >= 2) && (n <= MUXN_MAX_N);
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready register slice; in_ready depends only on state.
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         accept;
    logic         drain;

    assign accept = in_valid && !skid_valid_q;
    assign drain  = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (drain) begin
            // A full skid blocks accept, so the skid refill and a new load never collide.
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = in_data;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/muxn_pipe.sv
// N-input pipelined select stage with skid buffering; out-of-range selects pick input 0.
// Define MUXN_SEL_ERR_EN to add the sticky sel_err output.
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = muxn_sel_w(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]   s,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef MUXN_SEL_ERR_EN
    output logic               sel_err,
`endif
    output logic [WIDTH-1:0]   y,
    output logic [SEL_W-1:0]   y_src
);

    if (!muxn_n_ok(N)) begin : g_bad_n
        $error("muxn_pipe: N must be in 2..%0d", MUXN_MAX_N);
    end

    localparam logic [SEL_W:0] N_L = (SEL_W + 1)'(N);

    logic                   in_range;
    logic [SEL_W-1:0]       sel;
    logic [WIDTH-1:0]       sel_data;
    logic [WIDTH+SEL_W-1:0] slot_out;

    assign in_range = ({1'b0, s} < N_L);
    assign sel      = in_range ? s : '0;

    always_comb begin
        sel_data = d[WIDTH-1:0];
        for (int k = 1; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = d[k*WIDTH +: WIDTH];
            end
        end
    end

    skid_buf #(
        .W(WIDTH + SEL_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({sel, sel_data}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (slot_out)
    );

    assign y     = slot_out[WIDTH-1:0];
    assign y_src = slot_out[WIDTH +: SEL_W];

`ifdef MUXN_SEL_ERR_EN
    logic sel_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (in_valid && in_ready && !in_range) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed bench for muxn_pipe: queue-based reference model plus hand-computed expectations.
module tb_muxn_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv4, ir4, ov4, or4;
    logic [127:0] d4;
    logic [1:0]   s4, ysrc4;
    logic [31:0]  y4;
    logic         iv3, ir3, ov3, or3;
    logic [47:0]  d3;
    logic [1:0]   s3, ysrc3;
    logic [15:0]  y3;
`ifdef MUXN_SEL_ERR_EN
    logic         serr4, serr3;
`endif

    int errors = 0;
    int checks = 0;

    muxn_pipe #(.WIDTH(32), .N(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .d(d4), .s(s4),
        .out_valid(ov4), .out_ready(or4),
`ifdef MUXN_SEL_ERR_EN
        .sel_err(serr4),
`endif
        .y(y4), .y_src(ysrc4)
    );

    muxn_pipe #(.WIDTH(16), .N(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .d(d3), .s(s3),
        .out_valid(ov3), .out_ready(or3),
`ifdef MUXN_SEL_ERR_EN
        .sel_err(serr3),
`endif
        .y(y3), .y_src(ysrc3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each DUT is a FIFO of capacity 2; the head is what y shows.
    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
    } item_t;

    item_t       m4[$];
    item_t       m3[$];
    logic [31:0] my4, my3;
    logic [1:0]  ms4, ms3;
    bit          me4, me3;
    bit          started = 0;

    always @(posedge clk) begin
        int  src;
        bit  acc, drn;
        if (rst) begin
            m4.delete(); m3.delete();
            my4 = 0; my3 = 0; ms4 = 0; ms3 = 0; me4 = 0; me3 = 0;
            started = 1;
        end else begin
            acc = iv4 && (m4.size() < 2);
            drn = (m4.size() > 0) && or4;
            if (drn) void'(m4.pop_front());
            if (acc) begin
                src = (int'(s4) < 4) ? int'(s4) : 0;
                if (int'(s4) >= 4) me4 = 1;
                m4.push_back({2'(src), d4[src*32 +: 32]});
            end
            if (m4.size() > 0) begin
                my4 = m4[0].data; ms4 = m4[0].src;
            end

            acc = iv3 && (m3.size() < 2);
            drn = (m3.size() > 0) && or3;
            if (drn) void'(m3.pop_front());
            if (acc) begin
                src = (int'(s3) < 3) ? int'(s3) : 0;
                if (int'(s3) >= 3) me3 = 1;
                m3.push_back({2'(src), 16'h0, d3[src*16 +: 16]});
            end
            if (m3.size() > 0) begin
                my3 = m3[0].data; ms3 = m3[0].src;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_ov4",   ov4,   m4.size() > 0);
            chk("m_ir4",   ir4,   m4.size() < 2);
            chk("m_y4",    y4,    my4);
            chk("m_ysrc4", ysrc4, ms4);
            chk("m_ov3",   ov3,   m3.size() > 0);
            chk("m_ir3",   ir3,   m3.size() < 2);
            chk("m_y3",    y3,    my3[15:0]);
            chk("m_ysrc3", ysrc3, ms3);
`ifdef MUXN_SEL_ERR_EN
            chk("m_serr4", serr4, me4);
            chk("m_serr3", serr3, me3);
`endif
        end
    end

    logic [31:0] stream_exp[4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        rst = 1; iv4 = 0; or4 = 0; d4 = '0; s4 = 0;
        iv3 = 0; or3 = 0; d3 = '0; s3 = 0;
        repeat (2) step();
        rst = 0;
        chk("reset_ov",   ov4,   0);
        chk("reset_y",    y4,    0);
        chk("reset_ysrc", ysrc4, 0);
        chk("reset_ir",   ir4,   1);

        d4 = {32'h44, 32'h33, 32'h22, 32'h11};
        or4 = 1;
        for (int i = 0; i < 4; i++) begin
            iv4 = 1; s4 = 2'(i);
            step();
            chk("stream_y",    y4,    stream_exp[i]);
            chk("stream_ysrc", ysrc4, i);
            chk("stream_ov",   ov4,   1);
        end
        iv4 = 0;
        step();
        chk("stream_empty_ov", ov4, 0);
        chk("stream_hold_y",   y4,  32'h44);

        or4 = 0; iv4 = 1; s4 = 1;
        step();
        chk("bp_first_y",  y4,  32'h22);
        chk("bp_first_ir", ir4, 1);
        s4 = 2;
        step();
        chk("bp_full_ir", ir4, 0);
        chk("bp_full_y",  y4,  32'h22);
        s4 = 3;
        repeat (3) begin
            step();
            chk("bp_hold_y",  y4,  32'h22);
            chk("bp_hold_ir", ir4, 0);
        end
        iv4 = 0; or4 = 1;
        step();
        chk("bp_rel_y",  y4,  32'h33);
        chk("bp_rel_ir", ir4, 1);
        step();
        chk("bp_done_ov", ov4, 0);
        chk("bp_done_y",  y4,  32'h33);

        d3 = {16'h3333, 16'h2222, 16'hAAAA};
        or3 = 1; iv3 = 1; s3 = 2;
        step();
        chk("oor_inrange_y",    y3,    16'h3333);
        chk("oor_inrange_ysrc", ysrc3, 2);
`ifdef MUXN_SEL_ERR_EN
        chk("oor_inrange_serr", serr3, 0);
`endif
        s3 = 3;
        step();
        iv3 = 0;
        chk("oor_y",    y3,    16'hAAAA);
        chk("oor_ysrc", ysrc3, 0);
`ifdef MUXN_SEL_ERR_EN
        chk("oor_serr", serr3, 1);
`endif
        repeat (3) step();
`ifdef MUXN_SEL_ERR_EN
        chk("oor_serr_sticky", serr3, 1);
`endif

        or4 = 0; iv4 = 1; d4 = {32'h8, 32'h7, 32'h6, 32'h5}; s4 = 0;
        step();
        s4 = 1;
        step();
        chk("rmid_full_ir", ir4, 0);
        iv4 = 0; rst = 1;
        step();
        rst = 0;
        chk("rmid_ov", ov4, 0);
        chk("rmid_ir", ir4, 1);
        chk("rmid_y",  y4,  0);
`ifdef MUXN_SEL_ERR_EN
        chk("rmid_serr", serr3, 0);
`endif
        or4 = 1;
        repeat (3) step();
        chk("rmid_no_stale", ov4, 0);

        or4 = 1; iv4 = 1; s4 = 0; d4 = '0;
        for (int i = 0; i < 10; i++) begin
            d4[31:0] = 32'(i + 1);
            step();
            chk("sim_y",  y4,  i + 1);
            chk("sim_ir", ir4, 1);
            chk("sim_ov", ov4, 1);
        end
        iv4 = 0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
